// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
//   EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid
//   buffer. The main entry drives the outputs. The skid entry catches the one
//   entry that can arrive after backpressure, because in_ready is registered.
//   A synchronous flush squashes both entries. The WB and MEM control outputs
//   are masked to zero whenever out_valid is low, so a bubble never writes.
//
//   Optional feature (macro PIPE_STALL_CNT_EN): adds a saturating stall_cnt
//   output that counts cycles with out_valid && !out_ready. Only rst clears it.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   flush              squash all held entries and drop the incoming one
//   in_valid/in_ready  upstream handshake (in_ready comes from a register)
//   in_*               execute-stage fields
//   out_valid/out_ready downstream handshake
//   out_*              registered fields to the memory stage
//   stall_cnt          backpressure cycle count (PIPE_STALL_CNT_EN only)
module ex_mem_skid_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2,
   parameter int MEM_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_adder2,
   input  logic              in_zero,
   input  logic [DATA_W-1:0] in_aluresult,
   input  logic [DATA_W-1:0] in_readdata2,
   input  logic [REG_W-1:0]  in_mux,
   input  logic [WB_W-1:0]   in_wb,
   input  logic [MEM_W-1:0]  in_mem,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_adder2,
   output logic              out_zero,
   output logic [DATA_W-1:0] out_aluresult,
   output logic [DATA_W-1:0] out_readdata2,
   output logic [REG_W-1:0]  out_mux,
   output logic [WB_W-1:0]   out_wb,
`ifdef PIPE_STALL_CNT_EN
   output logic [MEM_W-1:0]  out_mem,
   output logic [CNT_W-1:0]  stall_cnt
`else
   output logic [MEM_W-1:0]  out_mem
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] adder2;
      logic              zero;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rd2;
      logic [REG_W-1:0]  mux;
      logic [WB_W-1:0]   wb;
      logic [MEM_W-1:0]  mem;
   } ent_t;

   ent_t r_main, r_skid;
   logic r_main_vld, r_skid_vld, r_in_ready;

   ent_t w_in, w_main_nxt, w_skid_nxt;
   logic w_main_vld_nxt, w_skid_vld_nxt;
   logic w_accept, w_consume;

   assign w_in = '{adder2: in_adder2, zero: in_zero, alu: in_aluresult,
                   rd2: in_readdata2, mux: in_mux, wb: in_wb, mem: in_mem};

   // in_ready is only high while the skid is empty, so a full buffer ignores in_*
   assign w_accept  = in_valid && r_in_ready && !flush;
   assign w_consume = r_main_vld && out_ready;

   always_comb begin
      w_main_nxt     = r_main;
      w_skid_nxt     = r_skid;
      w_main_vld_nxt = r_main_vld;
      w_skid_vld_nxt = r_skid_vld;
      if (flush) begin
         w_main_vld_nxt = 1'b0;
         w_skid_vld_nxt = 1'b0;
      end else if (!r_main_vld || w_consume) begin
         // Main slot frees up: the older skid entry goes first to keep order
         if (r_skid_vld) begin
            w_main_nxt     = r_skid;
            w_main_vld_nxt = 1'b1;
            w_skid_vld_nxt = w_accept;
            if (w_accept) w_skid_nxt = w_in;
         end else begin
            w_main_vld_nxt = w_accept;
            if (w_accept) w_main_nxt = w_in;
         end
      end else if (w_accept) begin
         // Main is stalled: park the entry that arrived before in_ready fell
         w_skid_nxt     = w_in;
         w_skid_vld_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main     <= '0;
         r_skid     <= '0;
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         r_main_vld <= w_main_vld_nxt;
         r_skid_vld <= w_skid_vld_nxt;
         r_in_ready <= !w_skid_vld_nxt;
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_main_vld;
   assign out_adder2    = r_main.adder2;
   assign out_zero      = r_main.zero;
   assign out_aluresult = r_main.alu;
   assign out_readdata2 = r_main.rd2;
   assign out_mux       = r_main.mux;
   // Control fields are masked on bubbles so the memory stage never writes
   assign out_wb        = r_main_vld ? r_main.wb  : '0;
   assign out_mem       = r_main_vld ? r_main.mem : '0;

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (r_main_vld && !out_ready && (r_stall_cnt != {CNT_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;
   localparam int DATA_W = 32, REG_W = 5, WB_W = 2, MEM_W = 3, CNT_W = 4;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready, in_zero, out_valid, out_ready, out_zero;
   logic [DATA_W-1:0] in_adder2, in_aluresult, in_readdata2;
   logic [DATA_W-1:0] out_adder2, out_aluresult, out_readdata2;
   logic [REG_W-1:0]  in_mux, out_mux;
   logic [WB_W-1:0]   in_wb, out_wb;
   logic [MEM_W-1:0]  in_mem, out_mem;
`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0]  stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_mem_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W), .MEM_W(MEM_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_adder2(in_adder2), .in_zero(in_zero), .in_aluresult(in_aluresult),
      .in_readdata2(in_readdata2), .in_mux(in_mux), .in_wb(in_wb), .in_mem(in_mem),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_adder2(out_adder2), .out_zero(out_zero), .out_aluresult(out_aluresult),
      .out_readdata2(out_readdata2), .out_mux(out_mux), .out_wb(out_wb),
`ifdef PIPE_STALL_CNT_EN
      .out_mem(out_mem), .stall_cnt(stall_cnt)
`else
      .out_mem(out_mem)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [1:0] wb, input logic [2:0] mem);
      in_valid     = v;
      in_aluresult = alu;
      in_wb        = wb;
      in_mem       = mem;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      in_valid = 1'b0; in_adder2 = '0; in_zero = 1'b0; in_aluresult = '0;
      in_readdata2 = '0; in_mux = '0; in_wb = '0; in_mem = '0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu", out_aluresult, 0);
      chk("rst_wb", out_wb, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // 1: single entry, one-cycle latency
      out_ready = 1'b1;
      in_adder2 = 32'h100; in_zero = 1'b1; in_readdata2 = 32'hDEAD; in_mux = 5'd7;
      drive(1'b1, 32'h10, 2'b10, 3'b001);
      tick();
      chk("t1_valid", out_valid, 1);
      chk("t1_alu", out_aluresult, 32'h10);
      chk("t1_wb", out_wb, 2'b10);
      chk("t1_mem", out_mem, 3'b001);
      chk("t1_mux", out_mux, 7);
      chk("t1_adder2", out_adder2, 32'h100);
      chk("t1_zero", out_zero, 1);
      chk("t1_rd2", out_readdata2, 32'hDEAD);
      chk("t1_in_ready", in_ready, 1);
      in_valid = 1'b0;
      tick();
      chk("t1_bubble_valid", out_valid, 0);
      chk("t1_bubble_wb", out_wb, 0);
      chk("t1_bubble_mem", out_mem, 0);
      chk("t1_bubble_alu_hold", out_aluresult, 32'h10);

      // 2: back-to-back stream, no bubble
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, i, 2'b01, 3'b010);
         tick();
         chk("t2_valid", out_valid, 1);
         chk("t2_alu", out_aluresult, i);
      end
      in_valid = 1'b0;
      tick();
      chk("t2_drain", out_valid, 0);

      // 3: backpressure, skid fill, ordered drain
      out_ready = 1'b0;
      drive(1'b1, 32'hA, 2'b11, 3'b100);
      tick();
      chk("t3_A_main", out_aluresult, 32'hA);
      chk("t3_ready_after_A", in_ready, 1);
      drive(1'b1, 32'hB, 2'b11, 3'b100);
      tick();
      chk("t3_ready_after_B", in_ready, 0);
      chk("t3_A_held", out_aluresult, 32'hA);
      drive(1'b1, 32'hC, 2'b11, 3'b100);
      tick();
      chk("t3_full_alu", out_aluresult, 32'hA);
      chk("t3_full_ready", in_ready, 0);
      chk("t3_full_valid", out_valid, 1);
      tick();
      chk("t3_full2_alu", out_aluresult, 32'hA);
      out_ready = 1'b1;
      tick();
      chk("t3_B_out", out_aluresult, 32'hB);
      chk("t3_B_valid", out_valid, 1);
      chk("t3_ready_rise", in_ready, 1);
      tick();
      chk("t3_C_out", out_aluresult, 32'hC);
      chk("t3_C_valid", out_valid, 1);
      in_valid = 1'b0;
      tick();
      chk("t3_drain", out_valid, 0);

      // 4: flush with a full buffer and an incoming entry
      out_ready = 1'b0;
      drive(1'b1, 32'hD, 2'b01, 3'b010);
      tick();
      drive(1'b1, 32'hE, 2'b01, 3'b010);
      tick();
      chk("t4_full", in_ready, 0);
      flush = 1'b1;
      drive(1'b1, 32'hF, 2'b11, 3'b111);
      tick();
      chk("t4_valid", out_valid, 0);
      chk("t4_wb", out_wb, 0);
      chk("t4_mem", out_mem, 0);
      chk("t4_in_ready", in_ready, 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("t4_F_dropped", out_valid, 0);
      tick();
      chk("t4_F_dropped2", out_valid, 0);

      // 5: reset mid-operation with both entries full
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 2'b10, 3'b011);
      tick();
      drive(1'b1, 32'h22, 2'b10, 3'b011);
      tick();
      chk("t5_full", in_ready, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("t5_valid", out_valid, 0);
      chk("t5_alu", out_aluresult, 0);
      chk("t5_adder2", out_adder2, 0);
      chk("t5_rd2", out_readdata2, 0);
      chk("t5_zero", out_zero, 0);
      chk("t5_mux", out_mux, 0);
      chk("t5_wb", out_wb, 0);
      chk("t5_mem", out_mem, 0);
      chk("t5_in_ready_rst", in_ready, 0);
      rst = 1'b0;
      tick();
      chk("t5_in_ready_after", in_ready, 1);
      chk("t5_valid_after", out_valid, 0);

`ifdef PIPE_STALL_CNT_EN
      // 6: saturating stall counter, cleared only by reset
      chk("t6_cnt_zero", stall_cnt, 0);
      out_ready = 1'b0;
      drive(1'b1, 32'h33, 2'b01, 3'b001);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      chk("t6_cnt_sat", stall_cnt, 15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t6_cnt_flush_keep", stall_cnt, 15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_cnt_rst", stall_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
Parametrised EX/MEM pipeline register for the pipelined datapath. It carries the branch target, zero flag, ALU result, store data, destination register and WB/MEM control fields from the execute stage to the memory stage.
- Successor to the plain capture register.
- Adds a valid/ready handshake, a 2-entry skid buffer so the upstream stage can be stalled with registered backpressure, synchronous flush for branch squash, and bubble-safe control masking.

Parameters:
DATA_W, 32, width of branch target, ALU result and store data
REG_W, 5, destination register address width
WB_W, 2, write-back control field width
MEM_W, 3, memory control field width
CNT_W, 16, stall counter width (only with optional feature)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  squash all held entries (branch taken / exception)
in_valid  input  1  execute stage presents a valid entry
in_ready  output  1  register can accept an entry this cycle
in_adder2  input  DATA_W  branch target
in_zero  input  1  ALU zero flag
in_aluresult  input  DATA_W  ALU result / address
in_readdata2  input  DATA_W  store data
in_mux  input  REG_W  destination register
in_wb  input  WB_W  write-back control
in_mem  input  MEM_W  memory control
out_valid  output  1  memory stage entry valid
out_ready  input  1  memory stage consumes entry this cycle
out_adder2, out_zero, out_aluresult, out_readdata2, out_mux, out_wb, out_mem  output  same widths as inputs  registered fields to memory stage
stall_cnt  output  CNT_W  backpressure cycle count (only with PIPE_STALL_CNT_EN)

Behaviour:
- Clock `clk`, reset `rst`: synchronous, active-high. Reset is already decided and is fixed.
- Storage: main entry (drives outputs) and skid entry. Each entry has a valid bit.
- Accept: `in_valid && in_ready && !flush`. Consume: `out_valid && out_ready`.
- `in_ready` = !skid_valid, driven from a register. It is 0 while `rst` is high.
- Latency: an accepted entry appears on the out_* ports the next cycle when main is empty or is being consumed that cycle.
- Accept when main is empty or consumed: the entry goes to main. If the skid is valid at the same time, the skid moves to main and the new entry goes to skid. Order is always preserved.
- Accept when main is valid and not consumed: the entry goes to skid, and `in_ready` falls the next cycle.
- Consume with skid valid and no accept: skid moves to main, skid_valid clears, and `in_ready` rises the next cycle.
- Consume with skid empty and no accept: main_valid clears.
- Full (both entries valid, `out_ready`=0): all state holds, `in_ready`=0, and `in_*` is ignored even if `in_valid`=1.
- Simultaneous accept and consume with skid empty: main is replaced, with no bubble. Full throughput is 1 entry/cycle.
- Flush: next cycle both valids = 0, and `out_wb`/`out_mem` = 0. An entry presented in the flush cycle is dropped. Flush overrides accept and consume. The data fields of the dropped entries are don't-care.
- Bubble masking: whenever `out_valid`=0, `out_wb`=0 and `out_mem`=0, so the memory stage never writes on a bubble. The data outputs hold their last value.
- Reset: `out_valid`=0, all out_* fields = 0, skid cleared, `stall_cnt`=0, `in_ready`=0 during reset and 1 on the first cycle after.
- Reset mid-operation: all entries are discarded, with the same result as reset from idle.
- No arithmetic on the data path. Fields are stored bit-exact.

Optional Feature:
PIPE_STALL_CNT_EN
- Defined: `stall_cnt` port exists. It increments each cycle with `out_valid && !out_ready`, saturates at 2^CNT_W-1, and is cleared by `rst` only (not by flush).
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then `in_valid`=1, `out_ready`=1, in_aluresult=0x0000_0010, in_wb=2'b10, in_mux=5'd7 -> next cycle `out_valid`=1, out_aluresult=0x10, out_wb=2'b10, out_mux=7, `in_ready`=1.
2. Stream 4 back-to-back entries (ALU 1,2,3,4) with `out_ready`=1 -> outputs 1,2,3,4 on consecutive cycles with no bubble.
3. Hold `out_ready`=0 and send entries A=0xA, B=0xB, C=0xC -> A on outputs, B in skid, `in_ready`=0 after B, C held upstream. Raise `out_ready` -> order A, B, C, with no loss or duplication.
4. Full buffer, assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0, `out_wb`=0, `out_mem`=0, `in_ready`=1, and the flush-cycle entry is never output.
5. Assert `rst` for 1 cycle with both entries full -> `out_valid`=0, all out_* = 0, `in_ready`=0 during reset and 1 after.
6. With PIPE_STALL_CNT_EN and CNT_W=4: hold a valid entry with `out_ready`=0 for 20 cycles -> `stall_cnt`=15 (saturated). Then `rst` -> 0.
